uart_cfg_arbiter: RTL and testbench

UART_CFG_ARBITER -- requirements
Module: uart_cfg_arbiter

---
 rtl/uart_cfg_arbiter_if.sv | 39 +++
 rtl/uart_cfg_arbiter.sv | 158 +++++++++++++++
 tb/tb_uart_cfg_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cfg_arbiter_if.sv
// Requester/shared-bus bundle for uart_cfg_arbiter.
// master = requesters and bus target side; slave = the arbiter.
interface uart_cfg_arbiter_if #(
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 8
);
  logic [WIDTH_CONFIG_ADDR-1:0] m0_addr;
  logic [WIDTH_CONFIG_DATA-1:0] m0_data;
  logic                         m0_valid;
  logic                         m0_ready;
  logic [WIDTH_CONFIG_ADDR-1:0] m1_addr;
  logic [WIDTH_CONFIG_DATA-1:0] m1_data;
  logic                         m1_valid;
  logic                         m1_ready;
  logic [WIDTH_CONFIG_ADDR-1:0] c_addr;
  logic [WIDTH_CONFIG_DATA-1:0] c_data;
  logic                         c_valid;
  logic                         c_ready;
  logic [1:0]                   grant;
  logic                         timeout_err;

  modport master (
    output m0_addr, m0_data, m0_valid,
    output m1_addr, m1_data, m1_valid,
    output c_ready,
    input  m0_ready, m1_ready,
    input  c_addr, c_data, c_valid,
    input  grant, timeout_err
  );

  modport slave (
    input  m0_addr, m0_data, m0_valid,
    input  m1_addr, m1_data, m1_valid,
    input  c_ready,
    output m0_ready, m1_ready,
    output c_addr, c_data, c_valid,
    output grant, timeout_err
  );
endinterface

// File: rtl/uart_cfg_arbiter.sv
// Two-requester round-robin arbiter onto a shared config bus.
// Optional stall watchdog enabled by macro CFG_ARB_TIMEOUT_EN.
module uart_cfg_arbiter #(
  parameter int WIDTH_CONFIG_ADDR = 4,
  parameter int WIDTH_CONFIG_DATA = 8,
  parameter int TIMEOUT           = 255
) (
  input logic               clk,
  input logic               rst_n,
  uart_cfg_arbiter_if.slave bus
);

  localparam int AW = WIDTH_CONFIG_ADDR;
  localparam int DW = WIDTH_CONFIG_DATA;

  // Reject an out-of-range watchdog limit at elaboration
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("uart_cfg_arbiter: TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_state;
  logic [AW-1:0]   r_c_addr;
  logic [AW-1:0]   w_c_addr;
  logic [DW-1:0]   r_c_data;
  logic [DW-1:0]   w_c_data;
  logic            r_c_valid;
  logic            w_c_valid;
  logic [1:0]      r_grant;
  logic [1:0]      w_grant;
  logic [1:0]      r_ready;
  logic [1:0]      w_ready;
  logic            r_last;
  logic            w_last;
  logic            w_pick1;

`ifdef CFG_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0]     r_cnt;
  logic [15:0]     w_cnt;
  logic            r_terr;
  logic            w_terr;
`endif

  // Next-state and next-output decode
  always_comb begin
    w_state   = r_state;
    w_c_addr  = r_c_addr;
    w_c_data  = r_c_data;
    w_c_valid = r_c_valid;
    w_grant   = r_grant;
    w_ready   = 2'b00;
    w_last    = r_last;
    w_pick1   = bus.m1_valid &
                (~bus.m0_valid | ~r_last);
`ifdef CFG_ARB_TIMEOUT_EN
    w_cnt     = r_cnt;
    w_terr    = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        w_c_valid = 1'b0;
        w_grant   = 2'b00;
        if (bus.m0_valid || bus.m1_valid) begin
          w_state   = BUSY;
          w_c_valid = 1'b1;
          w_grant   = w_pick1 ? 2'b10 : 2'b01;
          w_c_addr  = w_pick1 ? bus.m1_addr
                              : bus.m0_addr;
          w_c_data  = w_pick1 ? bus.m1_data
                              : bus.m0_data;
`ifdef CFG_ARB_TIMEOUT_EN
          w_cnt     = 16'd0;
`endif
        end
      end
      BUSY: begin
        if (bus.c_ready) begin
          w_state   = DONE;
          w_c_valid = 1'b0;
          w_ready   = r_grant;
`ifdef CFG_ARB_TIMEOUT_EN
        end else if (r_cnt == CNT_LAST) begin
          w_state   = DONE;
          w_c_valid = 1'b0;
          w_ready   = r_grant;
          w_terr    = 1'b1;
        end else begin
          w_cnt     = r_cnt + 16'd1;
`endif
        end
      end
      DONE: begin
        w_state   = IDLE;
        w_c_valid = 1'b0;
        w_grant   = 2'b00;
        w_last    = r_grant[1];
      end
      default: begin
        w_state   = IDLE;
        w_c_valid = 1'b0;
        w_grant   = 2'b00;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_c_addr  <= '0;
      r_c_data  <= '0;
      r_c_valid <= 1'b0;
      r_grant   <= 2'b00;
      r_ready   <= 2'b00;
      r_last    <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_c_addr  <= w_c_addr;
      r_c_data  <= w_c_data;
      r_c_valid <= w_c_valid;
      r_grant   <= w_grant;
      r_ready   <= w_ready;
      r_last    <= w_last;
    end
  end

`ifdef CFG_ARB_TIMEOUT_EN
  // Stall counter and abort pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 16'd0;
      r_terr <= 1'b0;
    end else begin
      r_cnt  <= w_cnt;
      r_terr <= w_terr;
    end
  end

  assign bus.timeout_err = r_terr;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.c_addr   = r_c_addr;
  assign bus.c_data   = r_c_data;
  assign bus.c_valid  = r_c_valid;
  assign bus.grant    = r_grant;
  assign bus.m0_ready = r_ready[0];
  assign bus.m1_ready = r_ready[1];

endmodule

// File: tb/tb_uart_cfg_arbiter.sv
// Directed bench for uart_cfg_arbiter.
// Watchdog cases follow CFG_ARB_TIMEOUT_EN.
module tb_uart_cfg_arbiter;

`ifdef CFG_ARB_TIMEOUT_EN
  localparam int TO = 4;
  localparam int BP = 3;
`else
  localparam int TO = 255;
  localparam int BP = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  uart_cfg_arbiter_if #(
    .WIDTH_CONFIG_ADDR(4),
    .WIDTH_CONFIG_DATA(8)
  ) bus ();

  uart_cfg_arbiter #(
    .WIDTH_CONFIG_ADDR(4),
    .WIDTH_CONFIG_DATA(8),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // {c_valid, grant, c_addr, c_data, m1_ready, m0_ready, timeout_err}
  logic [17:0] obs;
  assign obs = {bus.c_valid, bus.grant, bus.c_addr, bus.c_data,
                bus.m1_ready, bus.m0_ready, bus.timeout_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.m0_addr = '0; bus.m0_data = '0; bus.m0_valid = 1'b0;
    bus.m1_addr = '0; bus.m1_data = '0; bus.m1_valid = 1'b0;
    bus.c_ready = 1'b0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clr_in();
    rst_n = 1'b0;
    #3;
    n_chk++;
    if (obs !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", obs, 18'h0);
    end
    #20;
    rst_n = 1'b1;
    step();
    n_chk++;
    if (obs !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_idle got=%h exp=%h", obs, 18'h0);
    end
  endtask

  task automatic test_single();
    bus.m0_addr = 4'h5; bus.m0_data = 8'hA3; bus.m0_valid = 1'b1;
    bus.c_ready = 1'b1;
    step();
    n_chk++;
    if (obs !== {1'b1, 2'b01, 4'h5, 8'hA3, 3'b000}) begin
      n_fail++;
      $display("FAIL single_busy got=%h exp=%h", obs,
               {1'b1, 2'b01, 4'h5, 8'hA3, 3'b000});
    end
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b01, 4'h5, 8'hA3, 3'b010}) begin
      n_fail++;
      $display("FAIL single_done got=%h exp=%h", obs,
               {1'b0, 2'b01, 4'h5, 8'hA3, 3'b010});
    end
    bus.m0_valid = 1'b0;
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b00, 4'h5, 8'hA3, 3'b000}) begin
      n_fail++;
      $display("FAIL single_idle got=%h exp=%h", obs,
               {1'b0, 2'b00, 4'h5, 8'hA3, 3'b000});
    end
  endtask

  task automatic test_tie();
    logic [1:0]  g;
    logic [11:0] ad;
    int          r0;
    int          r1;
    r0 = 0;
    r1 = 0;
    do_reset();
    bus.m0_addr = 4'h1; bus.m0_data = 8'h11; bus.m0_valid = 1'b1;
    bus.m1_addr = 4'h2; bus.m1_data = 8'h22; bus.m1_valid = 1'b1;
    bus.c_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g  = (k % 2 == 0) ? 2'b01 : 2'b10;
      ad = (k % 2 == 0) ? 12'h111 : 12'h222;
      step();
      n_chk++;
      if (obs !== {1'b1, g, ad, 3'b000}) begin
        n_fail++;
        $display("FAIL tie_grant%0d got=%h exp=%h", k, obs,
                 {1'b1, g, ad, 3'b000});
      end
      step();
      if (bus.m0_ready === 1'b1) r0++;
      if (bus.m1_ready === 1'b1) r1++;
      n_chk++;
      if (obs !== {1'b0, g, ad, g, 1'b0}) begin
        n_fail++;
        $display("FAIL tie_done%0d got=%h exp=%h", k, obs,
                 {1'b0, g, ad, g, 1'b0});
      end
      step();
      if (bus.m0_ready === 1'b1) r0++;
      if (bus.m1_ready === 1'b1) r1++;
      n_chk++;
      if (obs !== {1'b0, 2'b00, ad, 3'b000}) begin
        n_fail++;
        $display("FAIL tie_idle%0d got=%h exp=%h", k, obs,
                 {1'b0, 2'b00, ad, 3'b000});
      end
    end
    n_chk++;
    if (r0 !== 2 || r1 !== 2) begin
      n_fail++;
      $display("FAIL tie_ready_count got=%0d/%0d exp=2/2", r0, r1);
    end
    clr_in();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    bus.m1_addr = 4'hA; bus.m1_data = 8'h5C; bus.m1_valid = 1'b1;
    bus.c_ready = 1'b0;
    step();
    n_chk++;
    if (obs !== {1'b1, 2'b10, 4'hA, 8'h5C, 3'b000}) begin
      n_fail++;
      $display("FAIL bp_grant got=%h exp=%h", obs,
               {1'b1, 2'b10, 4'hA, 8'h5C, 3'b000});
    end
    for (int i = 0; i < BP; i++) begin
      step();
      if (obs !== {1'b1, 2'b10, 4'hA, 8'h5C, 3'b000}) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_stable got=%0d exp=0 unstable cycles", bad);
    end
    bus.c_ready = 1'b1;
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b10, 4'hA, 8'h5C, 3'b100}) begin
      n_fail++;
      $display("FAIL bp_done got=%h exp=%h", obs,
               {1'b0, 2'b10, 4'hA, 8'h5C, 3'b100});
    end
    bus.m1_valid = 1'b0;
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b00, 4'hA, 8'h5C, 3'b000}) begin
      n_fail++;
      $display("FAIL bp_idle got=%h exp=%h", obs,
               {1'b0, 2'b00, 4'hA, 8'h5C, 3'b000});
    end
  endtask

  task automatic test_valid_drop();
    bus.m1_addr = 4'h3; bus.m1_data = 8'h77; bus.m1_valid = 1'b1;
    bus.c_ready = 1'b0;
    step();
    bus.m1_valid = 1'b0; bus.m1_addr = 4'hF; bus.m1_data = 8'hFF;
    step();
    n_chk++;
    if (obs !== {1'b1, 2'b10, 4'h3, 8'h77, 3'b000}) begin
      n_fail++;
      $display("FAIL drop_busy got=%h exp=%h", obs,
               {1'b1, 2'b10, 4'h3, 8'h77, 3'b000});
    end
    bus.c_ready = 1'b1;
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b10, 4'h3, 8'h77, 3'b100}) begin
      n_fail++;
      $display("FAIL drop_done got=%h exp=%h", obs,
               {1'b0, 2'b10, 4'h3, 8'h77, 3'b100});
    end
    step();
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b00, 4'h3, 8'h77, 3'b000}) begin
      n_fail++;
      $display("FAIL drop_idle got=%h exp=%h", obs,
               {1'b0, 2'b00, 4'h3, 8'h77, 3'b000});
    end
  endtask

  task automatic test_timeout();
`ifdef CFG_ARB_TIMEOUT_EN
    int bad;
    bad = 0;
    bus.m0_addr = 4'h6; bus.m0_data = 8'h66; bus.m0_valid = 1'b1;
    bus.c_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs !== {1'b1, 2'b01, 4'h6, 8'h66, 3'b000}) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL to_stall got=%0d exp=0 bad cycles", bad);
    end
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b01, 4'h6, 8'h66, 3'b011}) begin
      n_fail++;
      $display("FAIL to_abort got=%h exp=%h", obs,
               {1'b0, 2'b01, 4'h6, 8'h66, 3'b011});
    end
    bus.m0_valid = 1'b0;
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b00, 4'h6, 8'h66, 3'b000}) begin
      n_fail++;
      $display("FAIL to_idle got=%h exp=%h", obs,
               {1'b0, 2'b00, 4'h6, 8'h66, 3'b000});
    end
    bus.m1_addr = 4'h7; bus.m1_data = 8'h71; bus.m1_valid = 1'b1;
    step();
    step();
    step();
    step();
    bus.c_ready = 1'b1;
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b10, 4'h7, 8'h71, 3'b100}) begin
      n_fail++;
      $display("FAIL to_tie_accept got=%h exp=%h", obs,
               {1'b0, 2'b10, 4'h7, 8'h71, 3'b100});
    end
    clr_in();
    step();
`else
    int bad;
    bad = 0;
    bus.m0_addr = 4'h6; bus.m0_data = 8'h66; bus.m0_valid = 1'b1;
    bus.c_ready = 1'b0;
    step();
    for (int i = 0; i < 310; i++) begin
      if (bus.c_valid !== 1'b1 || bus.timeout_err !== 1'b0) bad++;
      step();
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL noto_hold got=%0d exp=0 bad cycles", bad);
    end
    clr_in();
`endif
  endtask

  task automatic test_reset_busy();
    do_reset();
    bus.m0_addr = 4'h9; bus.m0_data = 8'h90; bus.m0_valid = 1'b1;
    bus.m1_addr = 4'hB; bus.m1_data = 8'hB0; bus.m1_valid = 1'b1;
    bus.c_ready = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== 18'h0) begin
      n_fail++;
      $display("FAIL rstbusy_async got=%h exp=%h", obs, 18'h0);
    end
    #2;
    rst_n = 1'b1;
    bus.c_ready = 1'b1;
    step();
    n_chk++;
    if (obs !== {1'b1, 2'b01, 4'h9, 8'h90, 3'b000}) begin
      n_fail++;
      $display("FAIL rstbusy_first got=%h exp=%h", obs,
               {1'b1, 2'b01, 4'h9, 8'h90, 3'b000});
    end
    step();
    n_chk++;
    if (obs !== {1'b0, 2'b01, 4'h9, 8'h90, 3'b010}) begin
      n_fail++;
      $display("FAIL rstbusy_done got=%h exp=%h", obs,
               {1'b0, 2'b01, 4'h9, 8'h90, 3'b010});
    end
    clr_in();
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_valid_drop();
    test_timeout();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
